combine_frame_ctrl: RTL

- Frame-level sequencer placed between the sub-FFT output lanes and the 4-lane serialising combiner.
- Detects frame starts and applies frame decimation.
- Generates the combiner's write strobe and write address, and registers the four 16-bit lanes in step with that strobe.
- Guards the combiner's 4*FFT_POINT output window, drops frames that arrive too early, and resets the combiner on a broken frame.

---
 rtl/combine_frame_ctrl.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/combine_frame_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// combine_frame_ctrl
//
// Frame-level sequencer between the sub-FFT output lanes and the 4-lane
// serialising combiner. It spots frame starts, applies frame decimation,
// produces the combiner write strobe/address, registers the four lanes in
// step with that strobe, and protects the combiner's 4*FFT_POINT output
// window by refusing frames that arrive while the previous one is still
// being captured or drained. A broken frame (missing beat or a stray
// start-of-packet) aborts the capture and resets the combiner.
//
// Optional build macro: FRAME_TAG_EN
//   When defined, lane_out0 on the first beat of every accepted frame
//   carries frame_cnt[15:0] (the post-increment value) instead of lane_in0.
//   FCNT_W must be at least 16 in that build.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   enable              arms frame acceptance
//   decim[7:0]          frames skipped between accepted frames
//   clr_status          pulse clearing drop_cnt, overrun, gap_err
//   in_valid, in_sop    upstream beat valid / first sample of a frame
//   lane_in0..3[15:0]   upstream lane samples
//   en_sync_out         combiner write strobe
//   cnt_sync_out        combiner write address
//   lane_out0..3[15:0]  registered lanes aligned with en_sync_out
//   comb_rst            combiner reset (rst or internal abort pulse)
//   busy                high while capturing or draining
//   frame_start         one-cycle pulse with the first accepted beat
//   frame_cnt           accepted frames (wrapping)
//   drop_cnt            frames refused while busy (saturating)
//   overrun, gap_err    sticky status flags
// ---------------------------------------------------------------------------
module combine_frame_ctrl #(
    parameter int FFT_POINT = 512,
    parameter int ADDR_W    = 9,
    parameter int GUARD     = 2,
    parameter int FCNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [7:0]        decim,
    input  logic              clr_status,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic [15:0]       lane_in0,
    input  logic [15:0]       lane_in1,
    input  logic [15:0]       lane_in2,
    input  logic [15:0]       lane_in3,
    output logic              en_sync_out,
    output logic [ADDR_W-1:0] cnt_sync_out,
    output logic [15:0]       lane_out0,
    output logic [15:0]       lane_out1,
    output logic [15:0]       lane_out2,
    output logic [15:0]       lane_out3,
    output logic              comb_rst,
    output logic              busy,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic [15:0]       drop_cnt,
    output logic              overrun,
    output logic              gap_err
);

    // The busy window spans 4*FFT_POINT+GUARD cycles, counted 1-based from
    // the first cycle after the accepted start beat.
    localparam int WIN_LAST = 4 * FFT_POINT + GUARD;
    localparam int WIN_W    = $clog2(WIN_LAST + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FFT_POINT - 1);
    localparam logic [WIN_W-1:0]  WIN_END   = WIN_W'(WIN_LAST);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOP,
        CAPTURE,
        DRAIN
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [7:0]        skip_cnt;
    logic [7:0]        skip_nx;
    logic [WIN_W-1:0]  win_cnt;
    logic              sop;
    logic              accept;
    logic              beat;
    logic              abort;
    logic              drop;
    logic              abort_q;
    logic [FCNT_W-1:0] frame_cnt_inc;

    assign sop           = in_valid & in_sop;
    assign frame_cnt_inc = frame_cnt + FCNT_W'(1);
    assign busy          = (state == CAPTURE) || (state == DRAIN);
    assign comb_rst      = rst | abort_q;

    // State register of the frame sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and per-beat decisions. accept marks the start beat of an
    // accepted frame, beat marks every later good beat, abort marks a broken
    // frame and drop marks a start beat that had to be refused. A stray sop
    // during capture both breaks the current frame and counts as a refused
    // frame. A skip count left above a freshly lowered decim is treated as
    // "due", so the frame is taken rather than waiting for a wrap.
    always_comb begin
        state_nx = state;
        skip_nx  = skip_cnt;
        accept   = 1'b0;
        beat     = 1'b0;
        abort    = 1'b0;
        drop     = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nx = WAIT_SOP;
                end
            end
            WAIT_SOP: begin
                if (!enable) begin
                    state_nx = IDLE;
                end else if (sop) begin
                    if (skip_cnt >= decim) begin
                        accept   = 1'b1;
                        skip_nx  = 8'd0;
                        state_nx = CAPTURE;
                    end else begin
                        skip_nx = skip_cnt + 8'd1;
                    end
                end
            end
            CAPTURE: begin
                if (in_valid && !in_sop) begin
                    beat = 1'b1;
                    if (cnt_sync_out + ADDR_W'(1) == LAST_ADDR) begin
                        state_nx = DRAIN;
                    end
                end else begin
                    abort    = 1'b1;
                    drop     = sop;
                    state_nx = WAIT_SOP;
                end
            end
            DRAIN: begin
                drop = sop;
                if (win_cnt == WIN_END) begin
                    state_nx = enable ? WAIT_SOP : IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Window counter: starts at 1 on the first busy cycle and advances every
    // busy cycle, so it doubles as the index of the current busy cycle. It
    // returns to 0 whenever the sequencer leaves the busy states.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt <= '0;
        end else if (accept) begin
            win_cnt <= WIN_W'(1);
        end else if ((state == CAPTURE && !abort) ||
                     (state == DRAIN && state_nx == DRAIN)) begin
            win_cnt <= win_cnt + WIN_W'(1);
        end else begin
            win_cnt <= '0;
        end
    end

    // Write strobe, write address, frame bookkeeping and the abort pulse
    // that feeds comb_rst. All of these appear one cycle after the input
    // beat they belong to. The address restarts at 0 on an abort so the
    // combiner never sees a stale partial address after its reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_sync_out  <= 1'b0;
            cnt_sync_out <= '0;
            frame_start  <= 1'b0;
            frame_cnt    <= '0;
            abort_q      <= 1'b0;
            skip_cnt     <= 8'd0;
        end else begin
            en_sync_out <= accept | beat;
            frame_start <= accept;
            abort_q     <= abort;
            skip_cnt    <= skip_nx;
            if (accept) begin
                cnt_sync_out <= '0;
                frame_cnt    <= frame_cnt_inc;
            end else if (beat) begin
                cnt_sync_out <= cnt_sync_out + ADDR_W'(1);
            end else if (abort) begin
                cnt_sync_out <= '0;
            end
        end
    end

    // Lane pipeline: a plain one-cycle delay so the lanes line up with the
    // strobe. With frame tagging enabled the first beat of an accepted frame
    // replaces lane 0 with the new frame number.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_out0 <= 16'd0;
            lane_out1 <= 16'd0;
            lane_out2 <= 16'd0;
            lane_out3 <= 16'd0;
        end else begin
`ifdef FRAME_TAG_EN
            lane_out0 <= accept ? frame_cnt_inc[15:0] : lane_in0;
`else
            lane_out0 <= lane_in0;
`endif
            lane_out1 <= lane_in1;
            lane_out2 <= lane_in2;
            lane_out3 <= lane_in3;
        end
    end

    // Status: a refused frame or a broken frame always wins over a
    // coincident clear, so a clear can never hide the event that arrived
    // with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= 16'd0;
            overrun  <= 1'b0;
            gap_err  <= 1'b0;
        end else begin
            if (drop) begin
                overrun <= 1'b1;
                if (clr_status) begin
                    drop_cnt <= 16'd1;
                end else if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end else if (clr_status) begin
                drop_cnt <= 16'd0;
                overrun  <= 1'b0;
            end
            if (abort) begin
                gap_err <= 1'b1;
            end else if (clr_status) begin
                gap_err <= 1'b0;
            end
        end
    end

endmodule
